// File: rtl/mulu256.sv
// Sequential unsigned NxN radix-2 shift-add multiplier producing a 2N-bit product.
// Latency N edges from accept (0-operand shortcut: DONE on the accept edge); start is ignored while busy.
module mulu256 #(
   parameter int N  = 256,
   parameter int CW = $clog2(N+1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   mcand,
   input  logic [N-1:0]   mplr,
   output logic [2*N-1:0] prod,
   output logic           zero,
   output logic           busy,
   output logic           data_rdy,
   output logic [2:0]     state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CALC = 3'd1,
      DONE = 3'd2
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(N-1);

   state_t         state_q, state_d;
   logic [N-1:0]   mcand_q, mcand_d;
   logic [2*N-1:0] prod_d;
   logic           zero_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N:0]     sum;

   assign state = state_q;

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      prod_d  = prod;
      zero_d  = zero;
      cnt_d   = cnt_q;
      // Carry out of the upper half is kept and shifted back in.
      sum     = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mcand_q} : '0);
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d = mcand;
               cnt_d   = '0;
               if (mcand == '0 || mplr == '0) begin
                  prod_d  = '0;
                  zero_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  prod_d  = {{N{1'b0}}, mplr};
                  zero_d  = 1'b0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            prod_d = {sum, prod[N-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         prod     <= '0;
         zero     <= 1'b0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         data_rdy <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         prod     <= prod_d;
         zero     <= zero_d;
         cnt_q    <= cnt_d;
         busy     <= (state_d == CALC);
         data_rdy <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_mulu256.sv
// Bench for mulu256: N=256 directed cases plus an N=8 instance with randomized scoreboard run.
module tb_mulu256;

   logic         clk;
   logic         rst;
   logic         start;
   logic [255:0] mcand;
   logic [255:0] mplr;
   logic [511:0] prod;
   logic         zero;
   logic         busy;
   logic         data_rdy;
   logic [2:0]   state;

   logic         start8;
   logic [7:0]   mcand8;
   logic [7:0]   mplr8;
   logic [15:0]  prod8;
   logic         zero8;
   logic         busy8;
   logic         rdy8;
   logic [2:0]   state8;

   int n_chk  = 0;
   int n_pass = 0;

   logic [511:0] sb_prod[$];
   logic         sb_zero[$];
   logic [15:0]  sb_prod8[$];
   logic         sb_zero8[$];

   mulu256 dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mcand    (mcand),
      .mplr     (mplr),
      .prod     (prod),
      .zero     (zero),
      .busy     (busy),
      .data_rdy (data_rdy),
      .state    (state)
   );

   mulu256 #(.N(8)) dut8 (
      .clk      (clk),
      .rst      (rst),
      .start    (start8),
      .mcand    (mcand8),
      .mplr     (mplr8),
      .prod     (prod8),
      .zero     (zero8),
      .busy     (busy8),
      .data_rdy (rdy8),
      .state    (state8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic issue(input logic [255:0] a, input logic [255:0] b);
      @(negedge clk);
      mcand = a;
      mplr  = b;
      start = 1'b1;
      sb_prod.push_back({256'b0, a} * {256'b0, b});
      sb_zero.push_back(a == '0 || b == '0);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits for data_rdy, optionally disturbing inputs at CALC cycle poke_at.
   task automatic finish_op(input string tag, input int exp_lat, input int poke_at);
      int           lat = 0;
      logic         saw_busy = 1'b0;
      logic         busy_before = 1'b0;
      logic [511:0] ep;
      logic         ez;
      while (!data_rdy && lat < 600) begin
         saw_busy    = saw_busy | busy;
         busy_before = busy;
         if (lat == poke_at) begin
            start = 1'b1;
            mcand = 256'd9;
            mplr  = 256'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk({tag, "_lat"}, 512'(lat), 512'(exp_lat));
      chk({tag, "_busy_off"}, 512'(busy), 512'd0);
      chk({tag, "_state"}, 512'(state), 512'd2);
      if (exp_lat > 0) chk({tag, "_busy_before"}, 512'(busy_before), 512'd1);
      else chk({tag, "_never_busy"}, 512'(saw_busy), 512'd0);
      if (sb_prod.size() == 0) begin
         chk({tag, "_sb_empty"}, 512'd0, 512'd1);
      end else begin
         ep = sb_prod.pop_front();
         ez = sb_zero.pop_front();
         chk({tag, "_prod"}, prod, ep);
         chk({tag, "_zero"}, 512'(zero), 512'(ez));
      end
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      mcand8 = a;
      mplr8  = b;
      start8 = 1'b1;
      sb_prod8.push_back({8'b0, a} * {8'b0, b});
      sb_zero8.push_back(a == 8'd0 || b == 8'd0);
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic finish8(input string tag, input logic pokes);
      int          lat = 0;
      logic [15:0] ep;
      logic        ez;
      while (!rdy8 && lat < 40) begin
         if (pokes && busy8 && $urandom_range(0, 3) == 0) begin
            start8 = 1'b1;
            mcand8 = 8'($urandom);
            mplr8  = 8'($urandom);
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start8 = 1'b0;
      if (sb_prod8.size() == 0) begin
         chk({tag, "_sb_empty"}, 512'd0, 512'd1);
      end else begin
         ep = sb_prod8.pop_front();
         ez = sb_zero8.pop_front();
         chk({tag, "_lat"}, 512'(lat), ez ? 512'd0 : 512'd8);
         chk({tag, "_prod"}, 512'(prod8), 512'(ep));
         chk({tag, "_zero"}, 512'(zero8), 512'(ez));
      end
   endtask

   initial begin
      logic [255:0] ones;
      logic [255:0] hi_exp;
      logic         ok;
      logic [7:0]   ra;
      logic [7:0]   rb;

      rst    = 1'b0;
      start  = 1'b0;
      mcand  = '0;
      mplr   = '0;
      start8 = 1'b0;
      mcand8 = '0;
      mplr8  = '0;
      #1;
      chk("rst_prod", prod, 512'd0);
      chk("rst_zero", 512'(zero), 512'd0);
      chk("rst_busy", 512'(busy), 512'd0);
      chk("rst_rdy", 512'(data_rdy), 512'd0);
      chk("rst_state", 512'(state), 512'd0);
      @(negedge clk);
      rst = 1'b1;

      // All-ones squared: hi = ff..fe, lo = 00..01.
      ones   = '1;
      hi_exp = {{255{1'b1}}, 1'b0};
      issue(ones, ones);
      finish_op("ones", 256, -1);
      chk("ones_hi", 512'(prod[511:256]), 512'(hi_exp));
      chk("ones_lo", 512'(prod[255:0]), 512'd1);

      issue(256'd12, 256'd5);
      finish_op("m12x5", 256, -1);
      chk("m12x5_val", prod, 512'd60);
      ok = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (prod !== 512'd60 || data_rdy !== 1'b1 || zero !== 1'b0) ok = 1'b0;
      end
      chk("m12x5_hold", 512'(ok), 512'd1);

      issue(256'd100, 256'd0);
      finish_op("z100x0", 0, -1);
      issue(256'd0, 256'd7);
      finish_op("z0x7", 0, -1);
      issue(256'd0, 256'd0);
      finish_op("z0x0", 0, -1);

      // Start pulse with new operands at CALC cycle 10 must be ignored.
      issue(256'd5, 256'd7);
      finish_op("m5x7", 256, 10);
      chk("m5x7_val", prod, 512'd35);
      issue(256'd45, 256'd9);
      chk("restart_drop", 512'(data_rdy), 512'd0);
      finish_op("m45x9", 256, -1);
      chk("m45x9_val", prod, 512'd405);

      // Asynchronous reset between edges in the middle of CALC.
      issue(256'd7, 256'd9);
      repeat (99) @(negedge clk);
      chk("mid_busy", 512'(busy), 512'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_prod", prod, 512'd0);
      chk("arst_state", 512'(state), 512'd0);
      chk("arst_busy", 512'(busy), 512'd0);
      chk("arst_rdy", 512'(data_rdy), 512'd0);
      chk("arst_zero", 512'(zero), 512'd0);
      sb_prod.delete();
      sb_zero.delete();
      @(negedge clk);
      rst = 1'b1;
      issue(256'd3, 256'd3);
      finish_op("m3x3", 256, -1);
      chk("m3x3_val", prod, 512'd9);

      // N=8 instance.
      issue8(8'd255, 8'd255);
      finish8("n8_ff", 1'b0);
      chk("n8_ff_val", 512'(prod8), 512'h0000_FE01);
      issue8(8'd128, 8'd2);
      finish8("n8_128x2", 1'b0);
      chk("n8_128x2_val", 512'(prod8), 512'h0100);
      for (int i = 0; i < 1000; i++) begin
         ra = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         issue8(ra, rb);
         finish8("n8_rand", 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
